multicycle_controller: RTL and testbench

Control unit that sequences the shared 32-bit ALU through a multicycle RV32I subset: lw, sw, R-type, I-type ALU, beq, jal. Sits beside the datapath. Each cycle it sets the datapath mux selects, write enables and the 3-bit ALUControl code from the current state and the instruction-register fields. It runs one instruction at a time, with no pipelining.

---
 rtl/riscv_ctrl_pkg.sv | 116 +++++++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 102 ++++++++++
 tb/tb_multicycle_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes, datapath mux selects and the per-state control word.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    StReset, StFetch, StDecode, StMemAdr, StMemRead, StMemWb,
    StMemWrite, StExecR, StExecI, StAluWb, StJal, StBeq
  } state_e;

  localparam logic [6:0] OpLw  = 7'b0000011;
  localparam logic [6:0] OpSw  = 7'b0100011;
  localparam logic [6:0] OpR   = 7'b0110011;
  localparam logic [6:0] OpI   = 7'b0010011;
  localparam logic [6:0] OpBeq = 7'b1100011;
  localparam logic [6:0] OpJal = 7'b1101111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluAdd  = 3'b000;
  localparam logic [2:0] AluSub  = 3'b001;
  localparam logic [2:0] AluAnd  = 3'b010;
  localparam logic [2:0] AluOr   = 3'b011;
  localparam logic [2:0] AluXor  = 3'b100;
  localparam logic [2:0] AluSlt  = 3'b101;
  localparam logic [2:0] AluNone = 3'b111;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARs1   = 2'b10;

  localparam logic [1:0] SrcBRs2  = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word for a state; fields not set stay 0.
  function automatic ctrl_t state_ctrl(state_e st);
    ctrl_t c;
    c = '0;
    case (st)
      StFetch: begin
        c.ir_write   = 1'b1;
        c.alu_src_a  = SrcAPc;
        c.alu_src_b  = SrcBFour;
        c.alu_op     = AluOpAdd;
        c.result_src = ResAluResult;
        c.pc_update  = 1'b1;
      end
      StDecode: begin
        c.alu_src_a = SrcAOldPc;
        c.alu_src_b = SrcBImm;
      end
      StMemAdr: begin
        c.alu_src_a = SrcARs1;
        c.alu_src_b = SrcBImm;
      end
      StMemRead: c.adr_src = 1'b1;
      StMemWb: begin
        c.result_src = ResData;
        c.reg_write  = 1'b1;
      end
      StMemWrite: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      StExecR: begin
        c.alu_src_a = SrcARs1;
        c.alu_src_b = SrcBRs2;
        c.alu_op    = AluOpFunct;
      end
      StExecI: begin
        c.alu_src_a = SrcARs1;
        c.alu_src_b = SrcBImm;
        c.alu_op    = AluOpFunct;
      end
      StAluWb: c.reg_write = 1'b1;
      StJal: begin
        c.alu_src_a = SrcAOldPc;
        c.alu_src_b = SrcBFour;
        c.pc_update = 1'b1;
      end
      StBeq: begin
        c.alu_src_a = SrcARs1;
        c.alu_src_b = SrcBRs2;
        c.alu_op    = AluOpSub;
        c.branch    = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction function fields onto the shared ALU's
// 3-bit operation code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = AluAdd;
    case (ALUOp)
      AluOpAdd: ALUControl = AluAdd;
      AluOpSub: ALUControl = AluSub;
      AluOpFunct: begin
        case (funct3)
          3'b000:  ALUControl = (op5 && funct7b5) ? AluSub : AluAdd;
          3'b010:  ALUControl = AluSlt;
          3'b100:  ALUControl = AluXor;
          3'b110:  ALUControl = AluOr;
          3'b111:  ALUControl = AluAnd;
          default: ALUControl = AluNone;
        endcase
      end
      default: ALUControl = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: main FSM with registered Moore outputs,
// immediate-format decode and PC write-enable generation.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       IllegalOp
);

  state_e state_q, state_d;
  ctrl_t  ctrl_q;
  logic   legal_op;

  assign legal_op = (op == OpLw) || (op == OpSw) || (op == OpR) || (op == OpI) ||
                    (op == OpBeq) || (op == OpJal);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StReset:  state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        if ((op == OpLw) || (op == OpSw)) state_d = StMemAdr;
        else if (op == OpR)               state_d = StExecR;
        else if (op == OpI)               state_d = StExecI;
        else if (op == OpJal)             state_d = StJal;
        else if (op == OpBeq)             state_d = StBeq;
        else                              state_d = StFetch;
      end
      StMemAdr:   state_d = (op == OpLw) ? StMemRead : StMemWrite;
      StMemRead:  state_d = StMemWb;
      StMemWb:    state_d = StFetch;
      StMemWrite: state_d = StFetch;
      StExecR:    state_d = StAluWb;
      StExecI:    state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBeq:      state_d = StFetch;
      default:    state_d = StReset;
    endcase
  end

  // Control word is registered from the next state so outputs are glitch-free
  // and clear asynchronously with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StReset;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= state_ctrl(state_d);
    end
  end

  assign PCWrite   = ctrl_q.pc_update | (ctrl_q.branch & Zero);
  assign AdrSrc    = ctrl_q.adr_src;
  assign MemWrite  = ctrl_q.mem_write;
  assign IRWrite   = ctrl_q.ir_write;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign RegWrite  = ctrl_q.reg_write;
  // op is only meaningful once the IR has loaded, i.e. in DECODE.
  assign IllegalOp = (state_q == StDecode) && !legal_op;

  // Forced to 0 in RESET so every output is quiet while reset is applied.
  always_comb begin
    ImmSrc = ImmI;
    if (state_q != StReset) begin
      case (op)
        OpSw:    ImmSrc = ImmS;
        OpBeq:   ImmSrc = ImmB;
        OpJal:   ImmSrc = ImmJ;
        default: ImmSrc = ImmI;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (ctrl_q.alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle model compared every
// cycle, plus directed literal checks on key cycles.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = '0;
  logic [2:0] funct3 = '0;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  multicycle_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .Zero       (Zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegWrite   (RegWrite),
    .ALUControl (ALUControl),
    .IllegalOp  (IllegalOp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcwrite;
    logic       adrsrc;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] resultsrc;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [1:0] immsrc;
    logic       regwrite;
    logic [2:0] aluctl;
    logic       illegal;
  } obs_t;

  localparam int KLw = 0, KSw = 1, KR = 2, KI = 3, KJal = 4, KBeq = 5, KIll = 6;

  obs_t act, exp_o;
  int   n_chk = 0, n_pass = 0;
  bit   cmp_en = 1'b0;

  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc,
                RegWrite, ALUControl, IllegalOp};

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
  endtask

  always @(negedge clk) if (cmp_en) check("cycle", act, exp_o);

  function automatic bit is_legal(input logic [6:0] o);
    return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 || o == 7'b0010011 ||
           o == 7'b1100011 || o == 7'b1101111;
  endfunction

  function automatic int instr_len(input int k);
    case (k)
      KLw:     return 5;
      KBeq:    return 3;
      KIll:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == 7'b0100011) return 2'd1;
    if (o == 7'b1100011) return 2'd2;
    if (o == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [2:0] func_code(input logic [6:0] o, input logic [2:0] f3,
                                           input logic f7);
    case (f3)
      3'd0:    return (o[5] && f7) ? 3'd1 : 3'd0;
      3'd2:    return 3'd5;
      3'd4:    return 3'd4;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd7;
    endcase
  endfunction

  // Expected outputs for cycle s (0 = FETCH) of an instruction of kind k.
  function automatic obs_t model(input int k, input int s, input logic [6:0] o,
                                 input logic [2:0] f3, input logic f7, input logic z);
    obs_t r;
    r = '0;
    r.immsrc = imm_of(o);
    if (s == 0) begin
      r.irwrite = 1; r.srcb = 2; r.resultsrc = 2; r.pcwrite = 1;
    end else if (s == 1) begin
      r.srca = 1; r.srcb = 1; r.illegal = !is_legal(o);
    end else begin
      case (k)
        KLw, KSw: begin
          if (s == 2) begin r.srca = 2; r.srcb = 1; end
          else if (s == 3) begin r.adrsrc = 1; r.memwrite = (k == KSw); end
          else begin r.resultsrc = 1; r.regwrite = 1; end
        end
        KR, KI: begin
          if (s == 2) begin
            r.srca = 2; r.srcb = (k == KI) ? 2'd1 : 2'd0; r.aluctl = func_code(o, f3, f7);
          end else r.regwrite = 1;
        end
        KJal: begin
          if (s == 2) begin r.srca = 1; r.srcb = 2; r.pcwrite = 1; end
          else r.regwrite = 1;
        end
        KBeq: begin r.srca = 2; r.aluctl = 3'd1; r.pcwrite = z; end
        default: r = r;
      endcase
    end
    return r;
  endfunction

  // Called at posedge+1 of a FETCH cycle; returns at posedge+1 of the next FETCH.
  task automatic run_instr(input int k, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zval, input int lit_step,
                           input logic [2:0] lit_alu, input logic lit_pc, input logic lit_ill,
                           input bit first);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int s = 0; s < instr_len(k); s++) begin
      Zero = (zval < 0) ? 1'($urandom_range(0, 1)) : 1'(zval);
      exp_o = model(k, s, o, f3, f7, Zero);
      if (first && s == 0) begin
        #2;
        check("first_fetch_irwrite", IRWrite, 1);
        check("first_fetch_alusrcb", ALUSrcB, 2);
        check("first_fetch_pcwrite", PCWrite, 1);
      end
      if (s == lit_step) begin
        #2;
        check("lit_aluctl", ALUControl, lit_alu);
        check("lit_pcwrite", PCWrite, lit_pc);
        check("lit_illegal", IllegalOp, lit_ill);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_random();
    int k;
    logic [6:0] o;
    k = $urandom_range(0, 6);
    case (k)
      KLw:  o = 7'b0000011;
      KSw:  o = 7'b0100011;
      KR:   o = 7'b0110011;
      KI:   o = 7'b0010011;
      KJal: o = 7'b1101111;
      KBeq: o = 7'b1100011;
      default: begin
        o = 7'($urandom);
        while (is_legal(o)) o = 7'($urandom);
      end
    endcase
    run_instr(k, o, 3'($urandom), 1'($urandom), -1, -1, 3'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // sw on the bus during reset: ImmSrc must still read 0
    op = 7'b0100011;
    exp_o = '0;
    cmp_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(KLw, 7'b0000011, 3'd2, 1'b0, -1, 4, 3'd0, 1'b0, 1'b0, 1'b1);
    run_instr(KR, 7'b0110011, 3'd0, 1'b1, -1, 2, 3'd1, 1'b0, 1'b0, 1'b0);
    run_instr(KR, 7'b0110011, 3'd0, 1'b0, -1, 2, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr(KI, 7'b0010011, 3'd0, 1'b1, -1, 2, 3'd0, 1'b0, 1'b0, 1'b0);
    run_instr(KBeq, 7'b1100011, 3'd0, 1'b0, 1, 2, 3'd1, 1'b1, 1'b0, 1'b0);
    run_instr(KBeq, 7'b1100011, 3'd0, 1'b0, 0, 2, 3'd1, 1'b0, 1'b0, 1'b0);
    run_instr(KIll, 7'b1111111, 3'd0, 1'b0, -1, 1, 3'd0, 1'b0, 1'b1, 1'b0);
    run_instr(KI, 7'b0010011, 3'd2, 1'b0, -1, 2, 3'd5, 1'b0, 1'b0, 1'b0);
    run_instr(KI, 7'b0010011, 3'd4, 1'b0, -1, 2, 3'd4, 1'b0, 1'b0, 1'b0);
    run_instr(KR, 7'b0110011, 3'd6, 1'b1, -1, 2, 3'd3, 1'b0, 1'b0, 1'b0);
    run_instr(KR, 7'b0110011, 3'd7, 1'b0, -1, 2, 3'd2, 1'b0, 1'b0, 1'b0);
    run_instr(KR, 7'b0110011, 3'd1, 1'b0, -1, 2, 3'd7, 1'b0, 1'b0, 1'b0);
    run_instr(KJal, 7'b1101111, 3'd0, 1'b0, -1, 2, 3'd0, 1'b1, 1'b0, 1'b0);

    // sw interrupted by reset while MemWrite is high
    op = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
    for (int s = 0; s < 3; s++) begin
      Zero = 1'($urandom_range(0, 1));
      exp_o = model(KSw, s, op, funct3, funct7b5, Zero);
      @(posedge clk); #1;
    end
    exp_o = model(KSw, 3, op, funct3, funct7b5, Zero);
    #2 check("sw_memwrite_before_reset", MemWrite, 1);
    rst_n = 1'b0;
    exp_o = '0;
    #1;
    check("reset_async_memwrite", MemWrite, 0);
    check("reset_async_all", act, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_instr(KSw, 7'b0100011, 3'd2, 1'b0, -1, -1, 3'd0, 1'b0, 1'b0, 1'b1);

    repeat (200) run_random();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
